// File: rtl/ovi_vstore_rx_if.sv
// ovi_vstore_rx_if: bus bundle for the OVI vector-store receiver.
// slave  - the receiver (ovi_vstore_rx) side.
// master - the vector unit / LSU / memory-port side that drives it.
interface ovi_vstore_rx_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  store_valid;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  store_credit;
  logic                  memop_sync_start;
  logic                  memop_sync_end;
  logic                  cmd_valid;
  logic [CNT_WIDTH-1:0]  cmd_beats;
  logic                  cmd_ready;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [CNT_WIDTH-1:0]  mem_beat_idx;
  logic                  mem_last;
  logic                  mem_ready;
  logic                  busy;
  logic                  err_overflow;
  logic                  err_sync;

  modport slave (
    input  store_valid, store_data, memop_sync_start, cmd_valid, cmd_beats, mem_ready,
    output store_credit, memop_sync_end, cmd_ready, mem_valid, mem_data, mem_beat_idx,
           mem_last, busy, err_overflow, err_sync
  );

  modport master (
    output store_valid, store_data, memop_sync_start, cmd_valid, cmd_beats, mem_ready,
    input  store_credit, memop_sync_end, cmd_ready, mem_valid, mem_data, mem_beat_idx,
           mem_last, busy, err_overflow, err_sync
  );
endinterface

// File: rtl/ovi_vstore_rx.sv
// ovi_vstore_rx: core-side OVI vector-store receiver.
// Buffers store beats in a credit-managed FIFO, drains them to the memory port once the LSU
// gives the beat count of the open memop, and closes the memop with memop_sync_end.
// Optional: define OVI_VSTORE_RX_BYPASS_EN to let a beat hitting an empty FIFO in the ACTIVE
// state go straight to the memory port in the same cycle.
module ovi_vstore_rx #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic            clk,
  input logic            reset,
  ovi_vstore_rx_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StActive, StEnd} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_WIDTH-1:0]  beats_left_q, beat_idx_q;
  logic                  credit_q, err_overflow_q, err_sync_q;

  logic active, fifo_empty, fifo_full, deq, fifo_rd, bypass_take, fifo_wr, overflow;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Memory-port presentation and FIFO read/write decisions.
  always_comb begin
    active     = (state_q == StActive);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
`ifdef OVI_VSTORE_RX_BYPASS_EN
    bus.mem_valid = active && (!fifo_empty || bus.store_valid);
    bus.mem_data  = fifo_empty ? bus.store_data : fifo_mem[rptr_q];
`else
    bus.mem_valid = active && !fifo_empty;
    bus.mem_data  = fifo_mem[rptr_q];
`endif
    deq         = bus.mem_valid && bus.mem_ready;
    fifo_rd     = deq && !fifo_empty;
    // Only reachable with bypass: the consumed beat never touches the FIFO.
    bypass_take = deq && fifo_empty;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    fifo_wr     = bus.store_valid && !bypass_take && (!fifo_full || fifo_rd);
    overflow    = bus.store_valid && fifo_full && !fifo_rd;
  end

  assign bus.store_credit   = credit_q;
  assign bus.memop_sync_end = (state_q == StEnd);
  assign bus.cmd_ready      = (state_q == StArmed);
  assign bus.busy           = (state_q != StIdle);
  assign bus.mem_beat_idx   = beat_idx_q;
  assign bus.mem_last       = active && (beats_left_q == CNT_WIDTH'(1));
  assign bus.err_overflow   = err_overflow_q;
  assign bus.err_sync       = err_sync_q;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wptr_q] <= bus.store_data;
  end

  // FIFO pointers, occupancy, credit pulse and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      credit_q       <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      if (fifo_wr) wptr_q <= ptr_inc(wptr_q);
      if (fifo_rd) rptr_q <= ptr_inc(rptr_q);
      count_q  <= count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      credit_q <= deq;
      if (overflow) err_overflow_q <= 1'b1;
    end
  end

  // Memop sequencing: IDLE -> ARMED -> ACTIVE -> END -> IDLE, plus beat counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      beats_left_q <= '0;
      beat_idx_q   <= '0;
      err_sync_q   <= 1'b0;
    end else begin
      if (bus.memop_sync_start && (state_q != StIdle)) err_sync_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (bus.memop_sync_start) state_q <= StArmed;
        end
        StArmed: begin
          if (bus.cmd_valid) begin
            beats_left_q <= bus.cmd_beats;
            beat_idx_q   <= '0;
            state_q      <= (bus.cmd_beats == '0) ? StEnd : StActive;
          end
        end
        StActive: begin
          if (deq) begin
            beat_idx_q   <= beat_idx_q + CNT_WIDTH'(1);
            beats_left_q <= beats_left_q - CNT_WIDTH'(1);
            if (beats_left_q == CNT_WIDTH'(1)) state_q <= StEnd;
          end
        end
        StEnd: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: doc/ovi_vstore_rx.md
Name: ovi_vstore_rx

Overview:
- Core-side receiver for the OVI vector-store data path and memop sync handshake.
- Accepts 512-bit store beats from the vector unit into a credit-managed FIFO.
- Returns one credit pulse per drained entry.
- Drains beats to the core's store/memory port once the LSU supplies the beat count for the current memop.
- Closes each memop with a single-cycle memop_sync_end pulse.

Parameters:
- DATA_WIDTH, 512, store beat width in bits.
- DEPTH, 32, FIFO entries. Must equal the transmitter's initial store-credit count.
- CNT_WIDTH, 8, width of the LSU beat count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- store_valid  in  1  store beat valid from the vector unit.
- store_data  in  DATA_WIDTH  store beat. Little endian: bits [255:0] hold the lower vector register.
- store_credit  out  1  one-cycle pulse; returns one credit.
- memop_sync_start  in  1  pulse; vector unit opens a memop.
- memop_sync_end  out  1  pulse; core closes the memop.
- cmd_valid  in  1  LSU beat-count command valid.
- cmd_beats  in  CNT_WIDTH  number of beats in the memop.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- mem_valid  out  1  beat available to the memory port.
- mem_data  out  DATA_WIDTH  beat data.
- mem_beat_idx  out  CNT_WIDTH  beat index within the memop, 0-based.
- mem_last  out  1  marks the final beat of the memop.
- mem_ready  in  1  memory port accepts the beat.
- busy  out  1  state != IDLE.
- err_overflow  out  1  sticky; a beat arrived while the FIFO was full.
- err_sync  out  1  sticky; memop_sync_start arrived while state != IDLE.

Behaviour:
- Reset (async, applies mid-operation): FIFO pointers, count, beat counter, FSM and sticky errors all clear. Outputs store_credit, memop_sync_end, mem_valid, mem_last, cmd_ready, busy, err_* are all 0. No credits are returned for flushed entries.
- FIFO: circular, DEPTH entries, with wptr, rptr and an occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue: store_valid is accepted in any FSM state.
  - If the FIFO is full and no dequeue happens the same cycle: drop the beat and set err_overflow.
  - If the FIFO is full and a dequeue happens the same cycle: accept the beat; occupancy is unchanged.
- Dequeue: occurs on mem_valid && mem_ready. store_credit is a registered pulse in the cycle after each dequeue. One pulse per beat; consecutive dequeues produce consecutive pulses.
- mem_valid = (state == ACTIVE) && FIFO non-empty. mem_data = head entry, registered FIFO read, so the minimum latency from store_valid to mem_valid is 1 cycle.
- FSM states:
  - IDLE: on memop_sync_start go to ARMED.
  - ARMED: cmd_ready = 1. On cmd_valid, latch cmd_beats into beats_left and clear the beat index. If cmd_beats == 0, go to END; otherwise go to ACTIVE.
  - ACTIVE: on each dequeue, increment mem_beat_idx and decrement beats_left. mem_last = (beats_left == 1). A dequeue with mem_last high goes to END.
  - END: memop_sync_end = 1 for exactly one cycle, then go to IDLE.
- memop_sync_start outside IDLE: set err_sync; the pulse is otherwise ignored.
- Beats arriving in IDLE or ARMED stay buffered. Beats remaining after END belong to the next memop.
- Simultaneous memop_sync_start and store_valid in IDLE: both take effect.

Optional Feature:
- Macro: OVI_VSTORE_RX_BYPASS_EN.
- When defined: if state == ACTIVE, the FIFO is empty and store_valid is high, the beat is presented combinationally on mem_data/mem_valid in the same cycle.
  - If mem_ready is also high, the beat is consumed without being written to the FIFO. A credit pulse follows in the next cycle.
  - If mem_ready is low, the beat is enqueued normally.
- When undefined: no bypass; minimum latency is 1 cycle.

Test Plan:
- Single memop: sync_start, cmd_beats = 4, 4 beats with mem_ready = 1 -> mem_beat_idx 0..3, mem_last on idx 3, 4 credit pulses, memop_sync_end one cycle after the last dequeue, busy drops.
- Back-pressure/full: DEPTH = 32, 32 beats pushed with mem_ready = 0 -> count = 32, no err. 33rd beat -> err_overflow = 1 and the beat is dropped. Push concurrently with a dequeue while full -> accepted, no error.
- Early data: 2 beats arrive in IDLE, then sync_start and cmd_beats = 2 -> no mem_valid before ACTIVE. Both beats drain in order and data matches.
- Zero-length memop: cmd_beats = 0 -> ARMED to END directly, one memop_sync_end pulse, no mem_valid, no credits.
- Reset mid-op: assert reset during ACTIVE with 5 beats queued -> all outputs 0 immediately, FIFO empty after release, no credits emitted.
- Bypass (macro defined): ACTIVE, FIFO empty, store_valid and mem_ready in cycle N -> mem_valid in N, credit in N+1. Macro undefined -> mem_valid in N+1.
